// File: rtl/uniboard_bus_master.sv
// Uniboard bus master: turns framed command bytes from the UART receiver into one
// read or write cycle on the shared register bus, then streams a reply to the UART
// transmitter. Frame: address, control (bit7 = rw, bits2:0 = write length N), N data bytes.
`timescale 1ns/1ps
module uniboard_bus_master #(
   parameter int unsigned TIMEOUT_CYCLES = 12000,
   parameter logic [7:0]  ACK_BYTE       = 8'h06,
   parameter logic [7:0]  NAK_BYTE       = 8'h15
) (
   input  logic        clk_12MHz,
   input  logic        reset,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   inout  wire  [31:0] databus,
   input  logic [2:0]  reg_size,
   output logic [7:0]  register_addr,
   output logic        rw,
   output logic        select,
   output logic        busy
);

   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [2:0] {
      StIdle, StCtrl, StData, StSetup, StStrobe, StCapture, StRelease, StReply
   } state_t;

   state_t        state_q, state_d;
   logic [7:0]    addr_q, addr_d;
   logic          wr_q, wr_d;
   logic [2:0]    n_q, n_d;
   logic [1:0]    k_q, k_d;
   logic [31:0]   wdata_q, wdata_d;
   logic [31:0]   rdata_q, rdata_d;
   logic [2:0]    rem_q, rem_d;
   logic [1:0]    scnt_q, scnt_d;
   logic [TW-1:0] tcnt_q, tcnt_d;
   logic [7:0]    tx_data_q, tx_data_d;
   logic          tx_valid_q, tx_valid_d;
   logic          select_q, select_d;
   logic          drive_q, drive_d;
   logic          rw_q, rw_d;
   logic          tmo_hit;
   logic          bus_phase;

   assign tmo_hit = (tcnt_q == TW'(TIMEOUT_CYCLES - 1));

   // Frame parser, bus sequencer and reply streamer
   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      wr_d       = wr_q;
      n_d        = n_q;
      k_d        = k_q;
      wdata_d    = wdata_q;
      rdata_d    = rdata_q;
      rem_d      = rem_q;
      scnt_d     = scnt_q;
      tcnt_d     = '0;
      tx_data_d  = tx_data_q;
      tx_valid_d = tx_valid_q;

      unique case (state_q)
         StIdle: begin
            if (rx_valid) begin
               addr_d  = rx_data;
               state_d = StCtrl;
            end
         end
         StCtrl: begin
            if (rx_valid) begin
               wr_d = ~rx_data[7];
               n_d  = rx_data[2:0];
               if (rx_data[7]) begin
                  state_d = StSetup;
               end else if (rx_data[2:0] inside {[3'd1:3'd4]}) begin
                  state_d = StData;
                  k_d     = 2'd0;
                  wdata_d = '0;
               end else begin
                  // Malformed write length: answer NAK without touching the bus
                  state_d    = StReply;
                  tx_data_d  = NAK_BYTE;
                  tx_valid_d = 1'b1;
                  rem_d      = 3'd0;
               end
            end else if (tmo_hit) begin
               state_d = StIdle;
            end else begin
               tcnt_d = tcnt_q + TW'(1);
            end
         end
         StData: begin
            if (rx_valid) begin
               wdata_d[{k_q, 3'b000} +: 8] = rx_data;
               if ({1'b0, k_q} == n_q - 3'd1) begin
                  state_d = StSetup;
               end else begin
                  k_d = k_q + 2'd1;
               end
            end else if (tmo_hit) begin
               state_d = StIdle;
            end else begin
               tcnt_d = tcnt_q + TW'(1);
            end
         end
         StSetup: begin
            state_d = StStrobe;
            scnt_d  = 2'd0;
         end
         StStrobe: begin
            scnt_d = scnt_q + 2'd1;
            // Two select cycles for a write, three for a read
            if (scnt_q == (wr_q ? 2'd1 : 2'd2)) begin
               if (wr_q) begin
                  state_d = StRelease;
               end else begin
                  state_d = StCapture;
                  rdata_d = databus;
                  rem_d   = (reg_size inside {[3'd1:3'd4]}) ? reg_size : 3'd0;
               end
            end
         end
         StCapture: begin
            state_d    = StReply;
            tx_data_d  = {5'b00000, rem_q};
            tx_valid_d = 1'b1;
         end
         StRelease: begin
            state_d    = StReply;
            tx_data_d  = ACK_BYTE;
            tx_valid_d = 1'b1;
            rem_d      = 3'd0;
         end
         StReply: begin
            if (tx_ready) begin
               if (rem_q != 3'd0) begin
                  tx_data_d = rdata_q[7:0];
                  rdata_d   = rdata_q >> 8;
                  rem_d     = rem_q - 3'd1;
               end else begin
                  tx_valid_d = 1'b0;
                  state_d    = StIdle;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Bus controls are registered from the next state so select never glitches
   always_comb begin
      bus_phase = (state_d == StSetup) || (state_d == StStrobe) || (state_d == StRelease);
      drive_d   = bus_phase && wr_d;
      rw_d      = ~drive_d;
      select_d  = (state_d == StStrobe);
   end

   // State and output registers, synchronous reset
   always_ff @(posedge clk_12MHz) begin
      if (reset) begin
         state_q    <= StIdle;
         addr_q     <= 8'h00;
         wr_q       <= 1'b0;
         n_q        <= 3'd0;
         k_q        <= 2'd0;
         wdata_q    <= '0;
         rdata_q    <= '0;
         rem_q      <= 3'd0;
         scnt_q     <= 2'd0;
         tcnt_q     <= '0;
         tx_data_q  <= 8'h00;
         tx_valid_q <= 1'b0;
         select_q   <= 1'b0;
         drive_q    <= 1'b0;
         rw_q       <= 1'b1;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         wr_q       <= wr_d;
         n_q        <= n_d;
         k_q        <= k_d;
         wdata_q    <= wdata_d;
         rdata_q    <= rdata_d;
         rem_q      <= rem_d;
         scnt_q     <= scnt_d;
         tcnt_q     <= tcnt_d;
         tx_data_q  <= tx_data_d;
         tx_valid_q <= tx_valid_d;
         select_q   <= select_d;
         drive_q    <= drive_d;
         rw_q       <= rw_d;
      end
   end

   assign databus       = drive_q ? wdata_q : 'z;
   assign register_addr = addr_q;
   assign rw            = rw_q;
   assign select        = select_q;
   assign tx_data       = tx_data_q;
   assign tx_valid      = tx_valid_q;
   assign busy          = (state_q != StIdle);

endmodule

// File: tb/tb_uniboard_bus_master.sv
// Bench for uniboard_bus_master: a peripheral model answers reads, a bus monitor
// records each select pulse, and a reply scoreboard holds the expected UART bytes.
`timescale 1ns/1ps
module tb_uniboard_bus_master;

   logic        clk_12MHz = 1'b0;
   logic        reset     = 1'b1;
   logic [7:0]  rx_data   = 8'h00;
   logic        rx_valid  = 1'b0;
   logic        tx_ready  = 1'b0;
   logic [7:0]  tx_data;
   logic        tx_valid;
   wire  [31:0] databus;
   logic [2:0]  reg_size;
   logic [7:0]  register_addr;
   logic        rw;
   logic        select;
   logic        busy;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [7:0]  exp_q[$];
   logic [31:0] tx_exp;

   int          sel_rises = 0;
   int          run       = 0;
   int          last_run  = 0;
   int          max_run   = 0;
   logic        sel_prev  = 1'b0;
   logic [7:0]  wr_addr   = 8'h00;
   logic [31:0] wr_data   = 32'h0;
   logic        wr_rw     = 1'b1;

   uniboard_bus_master dut (
      .clk_12MHz     (clk_12MHz),
      .reset         (reset),
      .rx_data       (rx_data),
      .rx_valid      (rx_valid),
      .tx_data       (tx_data),
      .tx_valid      (tx_valid),
      .tx_ready      (tx_ready),
      .databus       (databus),
      .reg_size      (reg_size),
      .register_addr (register_addr),
      .rw            (rw),
      .select        (select),
      .busy          (busy)
   );

   always #5 clk_12MHz = ~clk_12MHz;

   // Peripheral register map
   function automatic logic [2:0] per_size(input logic [7:0] a);
      case (a)
         8'h22:   return 3'd4;
         8'h30:   return 3'd2;
         8'h31:   return 3'd6;
         default: return 3'd0;
      endcase
   endfunction

   function automatic logic [31:0] per_data(input logic [7:0] a);
      case (a)
         8'h22:   return 32'h0000_2EE0;
         8'h30:   return 32'hA1B2_C3D4;
         8'h31:   return 32'h1122_3344;
         default: return 32'h0000_0000;
      endcase
   endfunction

   assign reg_size = select ? per_size(register_addr) : 3'd0;
   assign databus  = (select && rw) ? per_data(register_addr) : 'z;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %h, expected %h", tag, obs, exp);
      end
   endtask

   // Randomised transmitter backpressure
   initial forever begin
      @(posedge clk_12MHz);
      #1;
      tx_ready = 1'($urandom_range(0, 1));
   end

   // Reply scoreboard: every transferred byte must match the head of the queue
   initial forever begin
      @(negedge clk_12MHz);
      if (!reset && tx_valid && tx_ready) begin
         if (exp_q.size() != 0) tx_exp = {24'h0, exp_q.pop_front()};
         else                   tx_exp = 32'hDEAD_0000;
         check("tx_byte", {24'h0, tx_data}, tx_exp);
      end
   end

   // Bus monitor: select pulse length and what was presented at its rising edge
   initial forever begin
      @(negedge clk_12MHz);
      if (select) begin
         if (!sel_prev) begin
            sel_rises++;
            wr_addr = register_addr;
            wr_data = databus;
            wr_rw   = rw;
         end
         run++;
         if (run > max_run) max_run = run;
      end else if (run != 0) begin
         last_run = run;
         run      = 0;
      end
      sel_prev = select;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed no finish, expected finish");
      $fatal(1, "watchdog");
   end

   task automatic send_byte(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      @(posedge clk_12MHz);
      #1;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
   endtask

   task automatic wait_idle(input int budget);
      for (int i = 0; i < budget; i++) begin
         @(negedge clk_12MHz);
         if (!busy) break;
      end
      check("busy_drop", 32'(busy), 0);
      check("idle_rw", 32'(rw), 1);
      check("idle_bus_released", $countones(databus), 0);
      @(posedge clk_12MHz);
      #1;
   endtask

   task automatic do_write(input logic [7:0] addr, input logic [7:0] ctrl, input logic [31:0] data);
      logic [2:0]  n;
      logic [31:0] sh;
      n  = ctrl[2:0];
      sh = data;
      exp_q.push_back(8'h06);
      send_byte(addr);
      send_byte(ctrl);
      for (int i = 0; i < int'(n); i++) begin
         send_byte(sh[7:0]);
         sh = sh >> 8;
      end
      @(negedge clk_12MHz);
      check("wr_setup_sel", 32'(select), 0);
      check("wr_setup_rw", 32'(rw), 0);
      check("wr_setup_bus", databus, data);
      @(negedge clk_12MHz);
      check("wr_strobe1", 32'(select), 1);
      @(negedge clk_12MHz);
      check("wr_strobe2", 32'(select), 1);
      @(negedge clk_12MHz);
      check("wr_release_sel", 32'(select), 0);
      check("wr_release_rw", 32'(rw), 0);
      check("wr_release_bus", databus, data);
      @(negedge clk_12MHz);
      check("wr_tx_valid", 32'(tx_valid), 1);
      wait_idle(200);
      check("wr_run", last_run, 2);
      check("wr_addr", 32'(wr_addr), 32'(addr));
      check("wr_data", wr_data, data);
      check("wr_rw", 32'(wr_rw), 0);
   endtask

   task automatic do_read(input logic [7:0] addr);
      logic [2:0]  sz;
      logic [31:0] d;
      sz = per_size(addr);
      d  = per_data(addr);
      if (sz >= 3'd1 && sz <= 3'd4) begin
         exp_q.push_back({5'b00000, sz});
         for (int i = 0; i < int'(sz); i++) begin
            exp_q.push_back(d[7:0]);
            d = d >> 8;
         end
      end else begin
         exp_q.push_back(8'h00);
      end
      send_byte(addr);
      send_byte(8'h80);
      @(negedge clk_12MHz);
      check("rd_setup_sel", 32'(select), 0);
      check("rd_setup_rw", 32'(rw), 1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_12MHz);
         check("rd_strobe", 32'(select), 1);
         check("rd_strobe_rw", 32'(rw), 1);
      end
      check("rd_addr", 32'(register_addr), 32'(addr));
      check("rd_bus_not_driven", databus, per_data(addr));
      @(negedge clk_12MHz);
      check("rd_capture_sel", 32'(select), 0);
      @(negedge clk_12MHz);
      check("rd_tx_valid", 32'(tx_valid), 1);
      wait_idle(200);
      check("rd_run", last_run, 3);
   endtask

   initial begin
      int rises;
      logic [7:0] bad_ctrl [2];
      bad_ctrl[0] = 8'h05;
      bad_ctrl[1] = 8'h00;

      // Reset state
      repeat (2) @(posedge clk_12MHz);
      @(negedge clk_12MHz);
      check("rst_select", 32'(select), 0);
      check("rst_rw", 32'(rw), 1);
      check("rst_addr", 32'(register_addr), 0);
      check("rst_bus", $countones(databus), 0);
      check("rst_tx_valid", 32'(tx_valid), 0);
      check("rst_tx_data", 32'(tx_data), 0);
      check("rst_busy", 32'(busy), 0);
      @(posedge clk_12MHz);
      #1;
      reset = 1'b0;

      do_write(8'h23, 8'h04, 32'd10000);
      do_read(8'h22);
      do_read(8'h7F);
      do_read(8'h31);

      // Bad write lengths: NAK, no bus cycle, next frame still works
      foreach (bad_ctrl[j]) begin
         rises = sel_rises;
         exp_q.push_back(8'h15);
         send_byte(8'h40);
         send_byte(bad_ctrl[j]);
         wait_idle(200);
         check("nak_no_select", sel_rises, rises);
      end
      do_write(8'h60, 8'h04, 32'hDEAD_BEEF);
      do_write(8'h41, 8'h01, 32'h0000_00AB);
      do_write(8'h42, 8'h7A, 32'h0000_5A3C);

      // A byte arriving mid bus cycle is dropped
      exp_q.push_back(8'h02);
      exp_q.push_back(8'hD4);
      exp_q.push_back(8'hC3);
      send_byte(8'h30);
      send_byte(8'h80);
      send_byte(8'h99);
      wait_idle(200);
      check("drop_run", last_run, 3);

      // Inter-byte timeout discards a partial frame silently
      rises = sel_rises;
      send_byte(8'h20);
      send_byte(8'h01);
      repeat (11990) @(negedge clk_12MHz);
      check("tmo_still_busy", 32'(busy), 1);
      wait_idle(20);
      check("tmo_no_select", sel_rises, rises);
      do_write(8'h24, 8'h02, 32'h0000_1234);

      // Reset while select is high
      send_byte(8'h50);
      send_byte(8'h04);
      send_byte(8'hEF);
      send_byte(8'hBE);
      send_byte(8'hAD);
      send_byte(8'hDE);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk_12MHz);
         if (select) break;
      end
      check("rst_mid_sel_seen", 32'(select), 1);
      reset = 1'b1;
      @(posedge clk_12MHz);
      #1;
      check("rst_mid_select", 32'(select), 0);
      check("rst_mid_bus", $countones(databus), 0);
      check("rst_mid_busy", 32'(busy), 0);
      check("rst_mid_tx_valid", 32'(tx_valid), 0);
      @(posedge clk_12MHz);
      #1;
      reset = 1'b0;
      do_write(8'h25, 8'h03, 32'h00C0_FFEE);
      do_read(8'h30);

      repeat (5) @(posedge clk_12MHz);
      check("sb_empty", exp_q.size(), 0);
      check("sel_max", max_run, 3);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
